// File: rtl/pc_gen_multi_if.sv
// Fetch-request channel between the PC generator and the fetch unit.
// The generator drives the request fields and the fetch unit drives ready.
interface pc_gen_multi_if #(
  parameter int XLEN = 64
);
  logic            valid;
  logic            ready;
  logic [XLEN-1:0] pc;
  logic            stale;
  logic            misalign;

  modport master (output valid, output pc, output stale, output misalign, input ready);
  modport slave  (input valid, input pc, input stale, input misalign, output ready);
endinterface

// File: rtl/pc_gen_multi.sv
// Fetch-stage PC generator: holds the fetch PC, arbitrates prioritised redirect
// sources, and parks a redirect that arrives while the current request is stalled.
module pc_gen_multi #(
  parameter int              XLEN         = 64,
  parameter int              NUM_REDIRECT = 4,
  parameter logic [XLEN-1:0] RESET_PC     = 64'h8000_0000,
  parameter int              INST_BYTES   = 4
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic [NUM_REDIRECT-1:0]             redirect_valid,
  input  logic [NUM_REDIRECT-1:0][XLEN-1:0]   redirect_pc,
  pc_gen_multi_if.master                      ireq,
  output logic [31:0]                         redirect_cnt
);

  localparam int SELW = (NUM_REDIRECT > 1) ? $clog2(NUM_REDIRECT) : 1;
  localparam int OFFW = $clog2(INST_BYTES);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_ISSUE,
    ST_REDIR_WAIT
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   w_pc_nxt;
  logic [XLEN-1:0]   r_pend_pc;
  logic [XLEN-1:0]   w_pend_pc_nxt;
  logic [SELW-1:0]   r_pend_src;
  logic [SELW-1:0]   w_pend_src_nxt;
  logic [31:0]       r_redirect_cnt;
  logic [SELW-1:0]   w_sel;
  logic              w_any_redir;
  logic              w_take_new;
  logic              w_load;
  logic              w_valid;
  logic              w_stale;

  // Lowest index wins: scan from the top so the last hit is the highest priority.
  always_comb begin
    w_sel = '0;
    for (int i = NUM_REDIRECT - 1; i >= 0; i--) begin
      if (redirect_valid[i]) w_sel = SELW'(i);
    end
  end

  assign w_any_redir = |redirect_valid;
  assign w_take_new  = w_any_redir && (w_sel <= r_pend_src);

  // NOTE: every output of this block is defaulted first so no path leaves a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_pend_pc_nxt  = r_pend_pc;
    w_pend_src_nxt = r_pend_src;
    w_load         = 1'b0;
    w_valid        = 1'b0;
    w_stale        = 1'b0;
    case (r_state)
      ST_BOOT: begin
        w_state_nxt = ST_ISSUE;
        if (w_any_redir) begin
          w_pc_nxt = redirect_pc[w_sel];
          w_load   = 1'b1;
        end
      end
      ST_ISSUE: begin
        w_valid = 1'b1;
        if (ireq.ready) begin
          if (w_any_redir) begin
            w_pc_nxt = redirect_pc[w_sel];
            w_stale  = 1'b1;
            w_load   = 1'b1;
          end else begin
            w_pc_nxt = r_pc + XLEN'(INST_BYTES);
          end
        end else if (w_any_redir) begin
          w_pend_pc_nxt  = redirect_pc[w_sel];
          w_pend_src_nxt = w_sel;
          w_state_nxt    = ST_REDIR_WAIT;
        end
      end
      ST_REDIR_WAIT: begin
        w_valid = 1'b1;
        w_stale = 1'b1;
        if (ireq.ready) begin
          w_pc_nxt    = w_take_new ? redirect_pc[w_sel] : r_pend_pc;
          w_load      = 1'b1;
          w_state_nxt = ST_ISSUE;
        end else if (w_take_new) begin
          w_pend_pc_nxt  = redirect_pc[w_sel];
          w_pend_src_nxt = w_sel;
        end
      end
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state        <= ST_BOOT;
      r_pc           <= RESET_PC;
      r_pend_pc      <= '0;
      r_pend_src     <= '0;
      r_redirect_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_pend_pc  <= w_pend_pc_nxt;
      r_pend_src <= w_pend_src_nxt;
      if (w_load && (r_redirect_cnt != 32'hFFFF_FFFF)) r_redirect_cnt <= r_redirect_cnt + 32'd1;
    end
  end

  // valid depends only on registered state, so ready never reaches it combinationally.
  assign ireq.valid   = w_valid;
  assign ireq.stale   = w_stale;
  assign ireq.pc      = r_pc;
  assign redirect_cnt = r_redirect_cnt;

  generate
    if (OFFW == 0) begin : g_no_align
      assign ireq.misalign = 1'b0;
    end else begin : g_align
      assign ireq.misalign = |r_pc[OFFW-1:0];
    end
  endgenerate

endmodule

// File: tb/tb_pc_gen_multi.sv
// Directed bench for pc_gen_multi: each task drives one scenario and checks
// the fetch request, stale tag and redirect counter against hand-computed values.
module tb_pc_gen_multi;

  logic              clk;
  logic              resetn;
  logic [3:0]        rv;
  logic [3:0][63:0]  rpc;
  logic [31:0]       cnt;
  int                n_checks;
  int                n_errors;

  pc_gen_multi_if #(.XLEN(64)) ireq_if ();

  pc_gen_multi #(
    .XLEN(64), .NUM_REDIRECT(4), .RESET_PC(64'h8000_0000), .INST_BYTES(4)
  ) dut (
    .clk(clk), .resetn(resetn), .redirect_valid(rv), .redirect_pc(rpc),
    .ireq(ireq_if), .redirect_cnt(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got running exp finished");
    $fatal(1, "watchdog expired");
  end

  // Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (ireq_if.valid !== 1'b0) begin n_errors++; $display("FAIL rst_valid: got %b exp 0", ireq_if.valid); end
    n_checks++; if (ireq_if.stale !== 1'b0) begin n_errors++; $display("FAIL rst_stale: got %b exp 0", ireq_if.stale); end
    n_checks++; if (cnt !== 32'd0) begin n_errors++; $display("FAIL rst_cnt: got %h exp 0", cnt); end
    resetn = 1'b1;
    #1;
    n_checks++; if (ireq_if.valid !== 1'b0) begin n_errors++; $display("FAIL boot_valid: got %b exp 0", ireq_if.valid); end
  endtask

  task automatic test_sequential();
    step(); #1;
    n_checks++; if (ireq_if.valid !== 1'b1) begin n_errors++; $display("FAIL seq_valid: got %b exp 1", ireq_if.valid); end
    n_checks++; if (ireq_if.pc !== 64'h8000_0000) begin n_errors++; $display("FAIL seq_pc0: got %h exp 80000000", ireq_if.pc); end
    n_checks++; if (ireq_if.stale !== 1'b0) begin n_errors++; $display("FAIL seq_stale: got %b exp 0", ireq_if.stale); end
    step(); #1;
    n_checks++; if (ireq_if.pc !== 64'h8000_0004) begin n_errors++; $display("FAIL seq_pc1: got %h exp 80000004", ireq_if.pc); end
    step(); #1;
    n_checks++; if (ireq_if.pc !== 64'h8000_0008) begin n_errors++; $display("FAIL seq_pc2: got %h exp 80000008", ireq_if.pc); end
    step();
  endtask

  task automatic test_stall();
    ireq_if.ready = 1'b0;
    #1;
    n_checks++; if (ireq_if.pc !== 64'h8000_000C) begin n_errors++; $display("FAIL stall_pc0: got %h exp 8000000c", ireq_if.pc); end
    step(); #1;
    n_checks++; if (ireq_if.pc !== 64'h8000_000C) begin n_errors++; $display("FAIL stall_hold: got %h exp 8000000c", ireq_if.pc); end
    n_checks++; if (ireq_if.valid !== 1'b1) begin n_errors++; $display("FAIL stall_valid: got %b exp 1", ireq_if.valid); end
    ireq_if.ready = 1'b1;
    step();
  endtask

  task automatic test_redirect_accept();
    rv = 4'b0110; rpc[1] = 64'h100; rpc[2] = 64'h200;
    #1;
    n_checks++; if (ireq_if.stale !== 1'b1) begin n_errors++; $display("FAIL acc_stale: got %b exp 1", ireq_if.stale); end
    n_checks++; if (ireq_if.pc !== 64'h8000_0010) begin n_errors++; $display("FAIL acc_oldpc: got %h exp 80000010", ireq_if.pc); end
    step(); rv = 4'b0000; #1;
    n_checks++; if (ireq_if.pc !== 64'h100) begin n_errors++; $display("FAIL acc_pc: got %h exp 100", ireq_if.pc); end
    n_checks++; if (cnt !== 32'd1) begin n_errors++; $display("FAIL acc_cnt: got %0d exp 1", cnt); end
    n_checks++; if (ireq_if.stale !== 1'b0) begin n_errors++; $display("FAIL acc_stale_clr: got %b exp 0", ireq_if.stale); end
  endtask

  task automatic test_pended_redirect();
    ireq_if.ready = 1'b0; rv = 4'b0100; rpc[2] = 64'h300;
    #1;
    n_checks++; if (ireq_if.stale !== 1'b0) begin n_errors++; $display("FAIL pend_stale0: got %b exp 0", ireq_if.stale); end
    step(); rv = 4'b0010; rpc[1] = 64'h400; #1;
    n_checks++; if (ireq_if.pc !== 64'h100) begin n_errors++; $display("FAIL pend_hold1: got %h exp 100", ireq_if.pc); end
    n_checks++; if (ireq_if.stale !== 1'b1) begin n_errors++; $display("FAIL pend_stale1: got %b exp 1", ireq_if.stale); end
    step(); rv = 4'b1000; rpc[3] = 64'h500; #1;
    n_checks++; if (ireq_if.pc !== 64'h100) begin n_errors++; $display("FAIL pend_hold2: got %h exp 100", ireq_if.pc); end
    step(); rv = 4'b0000; ireq_if.ready = 1'b1; #1;
    n_checks++; if (ireq_if.pc !== 64'h100) begin n_errors++; $display("FAIL pend_hold3: got %h exp 100", ireq_if.pc); end
    n_checks++; if (ireq_if.stale !== 1'b1) begin n_errors++; $display("FAIL pend_stale3: got %b exp 1", ireq_if.stale); end
    n_checks++; if (cnt !== 32'd1) begin n_errors++; $display("FAIL pend_cnt_wait: got %0d exp 1", cnt); end
    step(); #1;
    n_checks++; if (ireq_if.pc !== 64'h400) begin n_errors++; $display("FAIL pend_pc: got %h exp 400", ireq_if.pc); end
    n_checks++; if (cnt !== 32'd2) begin n_errors++; $display("FAIL pend_cnt: got %0d exp 2", cnt); end
    n_checks++; if (ireq_if.stale !== 1'b0) begin n_errors++; $display("FAIL pend_stale_clr: got %b exp 0", ireq_if.stale); end
    // A higher-priority redirect arriving on the accept cycle overrides the parked one.
    ireq_if.ready = 1'b0; rv = 4'b0100; rpc[2] = 64'h600;
    step(); ireq_if.ready = 1'b1; rv = 4'b0001; rpc[0] = 64'h640; #1;
    n_checks++; if (ireq_if.stale !== 1'b1) begin n_errors++; $display("FAIL override_stale: got %b exp 1", ireq_if.stale); end
    step(); rv = 4'b0000; #1;
    n_checks++; if (ireq_if.pc !== 64'h640) begin n_errors++; $display("FAIL override_pc: got %h exp 640", ireq_if.pc); end
    n_checks++; if (cnt !== 32'd3) begin n_errors++; $display("FAIL override_cnt: got %0d exp 3", cnt); end
  endtask

  task automatic test_wrap();
    rv = 4'b0001; rpc[0] = 64'hFFFF_FFFF_FFFF_FFFC;
    step(); rv = 4'b0000; #1;
    n_checks++; if (ireq_if.pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_errors++; $display("FAIL wrap_top: got %h exp fffffffffffffffc", ireq_if.pc); end
    n_checks++; if (ireq_if.misalign !== 1'b0) begin n_errors++; $display("FAIL wrap_misalign: got %b exp 0", ireq_if.misalign); end
    n_checks++; if (cnt !== 32'd4) begin n_errors++; $display("FAIL wrap_cnt: got %0d exp 4", cnt); end
    step(); #1;
    n_checks++; if (ireq_if.pc !== 64'h0) begin n_errors++; $display("FAIL wrap_zero: got %h exp 0", ireq_if.pc); end
    step(); #1;
    n_checks++; if (ireq_if.pc !== 64'h4) begin n_errors++; $display("FAIL wrap_four: got %h exp 4", ireq_if.pc); end
  endtask

  task automatic test_misalign();
    rv = 4'b0001; rpc[0] = 64'h102;
    step(); rv = 4'b0000; #1;
    n_checks++; if (ireq_if.pc !== 64'h102) begin n_errors++; $display("FAIL mis_pc: got %h exp 102", ireq_if.pc); end
    n_checks++; if (ireq_if.misalign !== 1'b1) begin n_errors++; $display("FAIL mis_flag: got %b exp 1", ireq_if.misalign); end
    n_checks++; if (cnt !== 32'd5) begin n_errors++; $display("FAIL mis_cnt: got %0d exp 5", cnt); end
    step(); #1;
    n_checks++; if (ireq_if.pc !== 64'h106) begin n_errors++; $display("FAIL mis_next: got %h exp 106", ireq_if.pc); end
  endtask

  task automatic test_saturation();
    logic [63:0] exp_pc;
    force dut.r_redirect_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_redirect_cnt;
    n_checks++; if (cnt !== 32'hFFFF_FFFE) begin n_errors++; $display("FAIL sat_preload: got %h exp fffffffe", cnt); end
    for (int k = 0; k < 3; k++) begin
      exp_pc = 64'h1000 + 64'(k) * 64'h10;
      rv = 4'b0001; rpc[0] = exp_pc;
      step(); rv = 4'b0000; #1;
      n_checks++; if (cnt !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL sat_cnt%0d: got %h exp ffffffff", k, cnt); end
      n_checks++; if (ireq_if.pc !== exp_pc) begin n_errors++; $display("FAIL sat_pc%0d: got %h exp %h", k, ireq_if.pc, exp_pc); end
    end
  endtask

  task automatic test_reset_in_wait();
    ireq_if.ready = 1'b0; rv = 4'b0001; rpc[0] = 64'h900;
    step(); rv = 4'b0000; #1;
    n_checks++; if (ireq_if.stale !== 1'b1) begin n_errors++; $display("FAIL rw_stale: got %b exp 1", ireq_if.stale); end
    resetn = 1'b0; #1;
    n_checks++; if (ireq_if.valid !== 1'b0) begin n_errors++; $display("FAIL rw_valid: got %b exp 0", ireq_if.valid); end
    n_checks++; if (ireq_if.stale !== 1'b0) begin n_errors++; $display("FAIL rw_stale_rst: got %b exp 0", ireq_if.stale); end
    n_checks++; if (cnt !== 32'd0) begin n_errors++; $display("FAIL rw_cnt: got %h exp 0", cnt); end
    step(); ireq_if.ready = 1'b1; resetn = 1'b1; #1;
    n_checks++; if (ireq_if.valid !== 1'b0) begin n_errors++; $display("FAIL rw_boot: got %b exp 0", ireq_if.valid); end
    step(); #1;
    n_checks++; if (ireq_if.pc !== 64'h8000_0000) begin n_errors++; $display("FAIL rw_pc0: got %h exp 80000000", ireq_if.pc); end
    n_checks++; if (ireq_if.stale !== 1'b0) begin n_errors++; $display("FAIL rw_nostale: got %b exp 0", ireq_if.stale); end
    step(); #1;
    n_checks++; if (ireq_if.pc !== 64'h8000_0004) begin n_errors++; $display("FAIL rw_pc1: got %h exp 80000004", ireq_if.pc); end
  endtask

  task automatic test_boot_redirect();
    resetn = 1'b0;
    step(); resetn = 1'b1; rv = 4'b1000; rpc[3] = 64'h700; #1;
    n_checks++; if (ireq_if.valid !== 1'b0) begin n_errors++; $display("FAIL br_valid: got %b exp 0", ireq_if.valid); end
    n_checks++; if (ireq_if.stale !== 1'b0) begin n_errors++; $display("FAIL br_stale: got %b exp 0", ireq_if.stale); end
    step(); rv = 4'b0000; #1;
    n_checks++; if (ireq_if.pc !== 64'h700) begin n_errors++; $display("FAIL br_pc: got %h exp 700", ireq_if.pc); end
    n_checks++; if (cnt !== 32'd1) begin n_errors++; $display("FAIL br_cnt: got %0d exp 1", cnt); end
    n_checks++; if (ireq_if.stale !== 1'b0) begin n_errors++; $display("FAIL br_stale_issue: got %b exp 0", ireq_if.stale); end
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    resetn        = 1'b0;
    ireq_if.ready = 1'b1;
    rv            = '0;
    rpc           = '0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_accept();
    test_pended_redirect();
    test_wrap();
    test_misalign();
    test_saturation();
    test_reset_in_wait();
    test_boot_redirect();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
